poly_reduce_seq: RTL and testbench
==================================

# poly_reduce_seq

Sequential coefficient-wise modular reduction stage that sits directly downstream of the polynomial subtractor. It latches one 256-coefficient polynomial of signed 32-bit words, with any value in the full int32 range. It maps every coefficient to the canonical range [0, Q) with Q = 8380417, using Dilithium reduce32 followed by caddq. It processes LANES coefficients per cycle and returns the whole polynomial on a valid/ready handshake.

## Interface
- LANES, 4, coefficients reduced per cycle; must divide 256 (legal: 1, 2, 4, 8, 16).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  a_in holds a polynomial to reduce.
- in_ready  out  1  block can accept a polynomial.
- a_in  in  8192  coefficient x at bits [32x+31:32x], signed two's complement.
- out_valid  out  1  c_out holds the reduced polynomial.
- out_ready  in  1  consumer accepts c_out.
- c_out  out  8192  coefficient x at bits [32x+31:32x], each in [0, Q-1].
- busy  out  1  high in RUN state.

## Operation
- Internal state: 8192-bit buffer `buf`, index counter `idx` (log2(256/LANES) bits), and FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready: buf<=a_in, idx<=0, go to RUN.
- RUN:
  - Each cycle, coefficients LANES·idx … LANES·idx+LANES-1 of buf are replaced in place by reduce(coeff); then idx<=idx+1.
  - When idx is at its last value (256/LANES-1), go to DONE on the same edge.
- DONE:
  - out_valid=1 and c_out=buf.
  - When out_ready: go to IDLE.
  - c_out and buf stay stable while out_ready=0.
- reduce(a), per coefficient:
  - t = (sext33(a) + 2^22) >>> 23 (arithmetic shift); the 33-bit add is mandatory, so a = 2^31-1 must not overflow.
  - r = a − t·Q, computed in at least 42 bits; the result fits in 32 bits, |r| ≤ 6283008.
  - out = r + Q if r < 0, else r.
  - Valid for every int32 input.
- in_valid is ignored outside IDLE, and a_in is not sampled.
- c_out equals buf in every state; it is only meaningful while out_valid=1.

## Timing
- Reset (async assert, state change takes effect immediately):
  - state=IDLE, idx=0, buf=0.
  - in_ready=1, out_valid=0, busy=0, c_out=0.
- A reset during RUN or DONE discards the polynomial; no partial output is flagged valid.
- Latency: the accepting edge is E0. RUN covers E1…E(256/LANES). out_valid rises after edge E(256/LANES). With LANES=4, out_valid is first high 64 cycles after the accepting edge.
- Throughput: at best one polynomial per 256/LANES + 2 cycles; no overlap between input and output.
- Handshakes:
  - A transfer occurs on a rising edge with valid && ready.
  - out_valid never drops without out_ready=1.
  - in_ready and out_valid are never high together.
- Outputs are registered-state decodes; there is no combinational path from in_valid or out_ready to any output.

## Structure
- Shared package (dilithium_pkg), reused by poly_sub and neighbouring stages:
  - N=256, COEFF_W=32, Q=8380417, POLY_W=N·COEFF_W.
  - State encoding localparams.
- Sub-module coeff_reduce32_caddq: combinational, 32-bit in, 32-bit out, instantiated LANES times.
- Top level contains:
  - FSM;
  - idx counter;
  - lane select/writeback via indexed part-select on buf.

## Test plan
- Directed values (LANES=4), one polynomial with coefficients:
  - 0 → 0.
  - 8380417 → 0.
  - −1 → 8380416.
  - 12345 → 12345.
  - 2147483647 → 2096895.
  - −2147483648 → 6283521.
  - 16760834 → 0.
  - −8380417 → 0.
  - Remaining coefficients random int32; compare against the ((a mod Q)+Q) mod Q model.
- Latency: accept at edge E0 → out_valid first high after edge E64; busy high for exactly 64 cycles; in_ready low from E0 until the output handshake completes.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid stays 1 and c_out is bit-stable; raising out_ready → one transfer, then in_ready=1 on the next cycle.
- Input ignored while busy: pulse in_valid with a different a_in during RUN → output still matches the first polynomial; exactly one output per accepted input.
- Reset mid-operation: assert rst at RUN cycle 30 →
  - immediately: out_valid=0, in_ready=1, c_out=0;
  - after reset: a new polynomial reduces correctly with full 64-cycle latency.
- Parameter sweep: LANES=1 and LANES=16 → same results as the model, with latencies of 256 and 16 cycles respectively.

Source files
------------

// File: rtl/dilithium_pkg.sv
// -----------------------------------------------------------------------------
// dilithium_pkg
// Shared constants and types for the Dilithium polynomial arithmetic stages
// (poly_sub, poly_reduce_seq and neighbours).
//   N        : coefficients per polynomial
//   COEFF_W  : width of one coefficient word
//   POLY_W   : width of a flattened polynomial bus
//   Q        : Dilithium modulus
//   ROUND    : rounding constant 2^22 used by reduce32, sized for the 33-bit add
//   state_t  : sequencer states shared by the multi-cycle stages
// -----------------------------------------------------------------------------
package dilithium_pkg;

   localparam int N       = 256;
   localparam int COEFF_W = 32;
   localparam int POLY_W  = N * COEFF_W;

   localparam logic [31:0] Q     = 32'd8380417;
   localparam logic [32:0] ROUND = 33'd4194304;

   // State encodings, kept as named constants so other stages can decode them.
   localparam logic [1:0] ENC_IDLE = 2'd0;
   localparam logic [1:0] ENC_RUN  = 2'd1;
   localparam logic [1:0] ENC_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ENC_IDLE,
      ST_RUN  = ENC_RUN,
      ST_DONE = ENC_DONE
   } state_t;

endpackage : dilithium_pkg

// File: rtl/coeff_reduce32_caddq.sv
// -----------------------------------------------------------------------------
// coeff_reduce32_caddq
// Combinational single-coefficient reduction: Dilithium reduce32 followed by
// caddq, mapping any signed 32-bit word onto the canonical range [0, Q).
// Ports:
//   a : input  coefficient, signed two's complement, full int32 range
//   r : output coefficient, unsigned, always in [0, Q-1]
// -----------------------------------------------------------------------------
module coeff_reduce32_caddq
   import dilithium_pkg::*;
(
   input  logic [COEFF_W-1:0] a,
   output logic [COEFF_W-1:0] r
);

   logic [32:0] sum_s;    // sign-extended a plus 2^22, 33 bits so 2^31-1 cannot wrap
   logic [9:0]  t_s;      // quotient estimate round(a / 2^23), signed
   logic [47:0] prod_s;   // t * Q, wide enough that nothing is lost before the subtract
   logic [47:0] diff_s;   // a - t*Q
   logic [31:0] red_s;    // reduce32 result, |red| <= 6283008, so it fits in 32 bits

   // reduce32 then conditional add of Q for negative remainders.
   always_comb begin
      sum_s  = {a[31], a} + ROUND;
      t_s    = 10'($signed(sum_s) >>> 23);
      prod_s = {{38{t_s[9]}}, t_s} * {16'd0, Q};
      diff_s = {{16{a[31]}}, a} - prod_s;
      red_s  = 32'(diff_s);
      if (red_s[31]) begin
         r = red_s + Q;
      end else begin
         r = red_s;
      end
   end

endmodule : coeff_reduce32_caddq

// File: rtl/poly_reduce_seq.sv
// -----------------------------------------------------------------------------
// poly_reduce_seq
// Sequential coefficient-wise reduction of a 256-coefficient polynomial into
// [0, Q). A polynomial is latched on an input handshake, reduced in place
// LANES coefficients per cycle, then offered on an output handshake.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   in_valid  : a_in holds a polynomial to reduce
//   in_ready  : block is idle and can accept a polynomial
//   a_in      : coefficient x at bits [32x+31:32x], signed
//   out_valid : c_out holds the reduced polynomial
//   out_ready : consumer accepts c_out
//   c_out     : coefficient x at bits [32x+31:32x], each in [0, Q-1]
//   busy      : reduction in progress
// Parameter:
//   LANES     : coefficients reduced per cycle, a power of two dividing 256
// -----------------------------------------------------------------------------
module poly_reduce_seq
   import dilithium_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [POLY_W-1:0] a_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [POLY_W-1:0] c_out,
   output logic              busy
);

   localparam int STEPS   = N / LANES;
   localparam int IDX_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int LANE_SH = $clog2(LANES * COEFF_W);
   localparam int BASE_W  = $clog2(POLY_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STEPS - 1);

   state_t              state_r;
   state_t              state_nxt;
   logic                accept_s;
   logic [IDX_W-1:0]    idx_r;
   logic [POLY_W-1:0]   data_r;
   logic [BASE_W-1:0]   base_s;
   logic                in_ready_r;
   logic                out_valid_r;
   logic                busy_r;

   logic [COEFF_W-1:0]  lane_in_s  [LANES];
   logic [COEFF_W-1:0]  lane_out_s [LANES];

   // Bit offset of the first coefficient of the current lane group;
   // LANES is a power of two, so idx * LANES * 32 is a plain shift.
   assign base_s = BASE_W'({idx_r, {LANE_SH{1'b0}}});

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_in_s[l] = data_r[base_s + BASE_W'(l * COEFF_W) +: COEFF_W];

      coeff_reduce32_caddq u_reduce (
         .a (lane_in_s[l]),
         .r (lane_out_s[l])
      );
   end

   // Next-state decode; accept_s marks the input handshake edge.
   always_comb begin
      state_nxt = state_r;
      accept_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               state_nxt = ST_RUN;
               accept_s  = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (idx_r == IDX_LAST) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_DONE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Lane-group counter; wraps to zero on the last RUN edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r <= {IDX_W{1'b0}};
      end else if (accept_s) begin
         idx_r <= {IDX_W{1'b0}};
      end else if (state_r == ST_RUN) begin
         idx_r <= idx_r + IDX_W'(1);
      end else begin
         idx_r <= idx_r;
      end
   end

   // Polynomial buffer: load on accept, in-place lane writeback while running,
   // otherwise hold so c_out is stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= {POLY_W{1'b0}};
      end else if (accept_s) begin
         data_r <= a_in;
      end else if (state_r == ST_RUN) begin
         for (int l = 0; l < LANES; l++) begin
            data_r[base_s + BASE_W'(l * COEFF_W) +: COEFF_W] <= lane_out_s[l];
         end
      end else begin
         data_r <= data_r;
      end
   end

   // Status flags registered from the next state so they track state_r exactly
   // and have no combinational path from in_valid or out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         in_ready_r  <= (state_nxt == ST_IDLE);
         out_valid_r <= (state_nxt == ST_DONE);
         busy_r      <= (state_nxt == ST_RUN);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign c_out     = data_r;

endmodule : poly_reduce_seq

// File: tb/tb_poly_reduce_seq.sv
// -----------------------------------------------------------------------------
// tb_poly_reduce_seq
// Scoreboard bench for poly_reduce_seq with LANES = 4, 1 and 16. Expected
// polynomials come from a mod-Q reference model and are queued on every
// accepted input; a monitor pops and compares whenever an output transfers,
// and also watches handshake, latency, busy length and hold behaviour.
// -----------------------------------------------------------------------------
module tb_poly_reduce_seq;
   import dilithium_pkg::*;

   typedef struct {
      int                k;
      logic [POLY_W-1:0] data;
      int                acc;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [POLY_W-1:0] a_in;
   logic              iv   [3];
   logic              ordy [3];
   logic              ir   [3];
   logic              ov   [3];
   logic              bsy  [3];
   logic [POLY_W-1:0] cout [3];

   int checks;
   int failures;
   int cyc;
   exp_t sb[$];

   logic              ov_prev    [3];
   logic              ordy_prev  [3];
   logic [POLY_W-1:0] cout_prev  [3];
   logic [POLY_W-1:0] last_out   [3];
   int                busy_cnt   [3];

   logic [31:0] dir_in  [8] = '{32'h00000000, 32'h007FE001, 32'hFFFFFFFF, 32'd12345,
                                32'h7FFFFFFF, 32'h80000000, 32'h00FFC002, 32'hFF801FFF};
   logic [31:0] dir_exp [8] = '{32'd0, 32'd0, 32'd8380416, 32'd12345,
                                32'd2096895, 32'd6283521, 32'd0, 32'd0};

   poly_reduce_seq #(.LANES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a_in(a_in),
      .out_valid(ov[0]), .out_ready(ordy[0]), .c_out(cout[0]), .busy(bsy[0]));
   poly_reduce_seq #(.LANES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a_in(a_in),
      .out_valid(ov[1]), .out_ready(ordy[1]), .c_out(cout[1]), .busy(bsy[1]));
   poly_reduce_seq #(.LANES(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a_in(a_in),
      .out_valid(ov[2]), .out_ready(ordy[2]), .c_out(cout[2]), .busy(bsy[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Cycles in RUN for each instance: 256 / LANES.
   function automatic int steps_of(input int k);
      if (k == 0) return 64;
      else if (k == 1) return 256;
      else return 16;
   endfunction

   // Reference: canonical residue ((a mod Q) + Q) mod Q of each signed word.
   function automatic logic [POLY_W-1:0] model(input logic [POLY_W-1:0] p);
      logic [POLY_W-1:0] o;
      longint a;
      longint r;
      for (int i = 0; i < N; i++) begin
         a = longint'($signed(p[32*i +: 32]));
         r = ((a % 64'sd8380417) + 64'sd8380417) % 64'sd8380417;
         o[32*i +: 32] = 32'(r);
      end
      return o;
   endfunction

   function automatic logic [POLY_W-1:0] rand_poly();
      logic [POLY_W-1:0] p;
      for (int i = 0; i < N; i++) begin
         case ($urandom_range(0, 7))
            0: p[32*i +: 32] = 32'h7FFFFFFF;
            1: p[32*i +: 32] = 32'h80000000;
            2: p[32*i +: 32] = 32'(($urandom_range(0, 600) - 300) * 8380417);
            default: p[32*i +: 32] = $urandom();
         endcase
      end
      return p;
   endfunction

   function automatic int count_k(input int k);
      int n = 0;
      foreach (sb[j]) if (sb[j].k == k) n++;
      return n;
   endfunction

   function automatic int find_k(input int k);
      foreach (sb[j]) if (sb[j].k == k) return j;
      return -1;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_poly(input int k, input logic [POLY_W-1:0] act, input logic [POLY_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         for (int i = 0; i < N; i++) begin
            if (act[32*i +: 32] !== exp[32*i +: 32]) begin
               $display("FAIL poly_k%0d: coeff %0d got %0d expected %0d (t=%0t)",
                        k, i, act[32*i +: 32], exp[32*i +: 32], $time);
               break;
            end
         end
      end
   endtask

   // Waits for in_ready, offers p for one edge and queues the expected result.
   task automatic send(input int k, input logic [POLY_W-1:0] p);
      exp_t e;
      int   n = 0;
      while (!ir[k] && n < 600) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("send_ready_k%0d", k), ir[k], 1);
      a_in  = p;
      iv[k] = 1'b1;
      @(posedge clk); #1;
      iv[k] = 1'b0;
      e.k    = k;
      e.data = model(p);
      e.acc  = cyc;
      sb.push_back(e);
   endtask

   // Bounded wait until every queued result for instance k has been consumed.
   task automatic drain(input int k);
      int n = 0;
      while (count_k(k) != 0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("drain_k%0d", k), count_k(k), 0);
      @(posedge clk); #1;
   endtask

   // Monitor: handshake rules, latency, busy length, hold stability, data.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int k = 0; k < 3; k++) begin
               ov_prev[k]   = 1'b0;
               ordy_prev[k] = 1'b0;
               busy_cnt[k]  = 0;
            end
         end else begin
            for (int k = 0; k < 3; k++) begin
               int pend;
               int j;
               pend = count_k(k);
               chk($sformatf("in_ready_idle_k%0d", k), ir[k], (pend == 0) ? 1 : 0);
               chk($sformatf("ready_valid_excl_k%0d", k), (ir[k] && ov[k]) ? 1 : 0, 0);
               if (bsy[k]) busy_cnt[k]++;
               if (ov_prev[k] && !ordy_prev[k]) begin
                  chk($sformatf("hold_valid_k%0d", k), ov[k], 1);
                  chk($sformatf("hold_cout_k%0d", k), (cout[k] === cout_prev[k]) ? 1 : 0, 1);
               end
               if (ov[k] && !ov_prev[k]) begin
                  j = find_k(k);
                  chk($sformatf("rise_pending_k%0d", k), (j >= 0) ? 1 : 0, 1);
                  if (j >= 0) chk($sformatf("latency_k%0d", k), cyc - sb[j].acc, steps_of(k));
                  chk($sformatf("busy_len_k%0d", k), busy_cnt[k], steps_of(k));
                  busy_cnt[k] = 0;
               end
               if (ov[k] && ordy[k]) begin
                  j = find_k(k);
                  chk($sformatf("out_pending_k%0d", k), (j >= 0) ? 1 : 0, 1);
                  if (j >= 0) begin
                     chk_poly(k, cout[k], sb[j].data);
                     last_out[k] = cout[k];
                     sb.delete(j);
                  end
               end
               ov_prev[k]   = ov[k];
               ordy_prev[k] = ordy[k];
               cout_prev[k] = cout[k];
            end
         end
      end
   end

   // Stimulus.
   initial begin
      logic [POLY_W-1:0] p;
      int n;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rst      = 1'b1;
      a_in     = {POLY_W{1'b0}};
      for (int k = 0; k < 3; k++) begin
         iv[k]   = 1'b0;
         ordy[k] = 1'b1;
      end

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_in_ready_k%0d", k), ir[k], 1);
         chk($sformatf("rst_out_valid_k%0d", k), ov[k], 0);
         chk($sformatf("rst_busy_k%0d", k), bsy[k], 0);
         chk($sformatf("rst_cout_zero_k%0d", k), (cout[k] == {POLY_W{1'b0}}) ? 1 : 0, 1);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed boundary coefficients, remainder random.
      p = rand_poly();
      for (int i = 0; i < 8; i++) p[32*i +: 32] = dir_in[i];
      send(0, p);
      drain(0);
      for (int i = 0; i < 8; i++)
         chk($sformatf("directed_c%0d", i), last_out[0][32*i +: 32], dir_exp[i]);

      // Random polynomials.
      repeat (3) begin
         send(0, rand_poly());
         drain(0);
      end

      // Backpressure: hold out_ready low for 20 cycles in DONE.
      ordy[0] = 1'b0;
      send(0, rand_poly());
      n = 0;
      while (!ov[0] && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_valid_seen", ov[0], 1);
      repeat (20) @(posedge clk);
      #1;
      chk("bp_valid_held", ov[0], 1);
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_in_ready_after", ir[0], 1);
      chk("bp_valid_dropped", ov[0], 0);
      chk("bp_sb_empty", count_k(0), 0);

      // Input offered while busy must be ignored.
      send(0, rand_poly());
      repeat (10) @(posedge clk);
      #1;
      a_in  = rand_poly();
      iv[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      iv[0] = 1'b0;
      drain(0);
      repeat (4) @(posedge clk);
      #1;
      chk("ignore_no_extra_output", ov[0], 0);

      // Reset in the middle of RUN.
      send(0, rand_poly());
      repeat (30) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", ov[0], 0);
      chk("midrst_in_ready", ir[0], 1);
      chk("midrst_busy", bsy[0], 0);
      chk("midrst_cout_zero", (cout[0] == {POLY_W{1'b0}}) ? 1 : 0, 1);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      send(0, rand_poly());
      drain(0);

      // LANES = 1 and LANES = 16.
      for (int k = 1; k < 3; k++) begin
         repeat (2) begin
            send(k, rand_poly());
            drain(k);
         end
      end

      chk("sb_empty_end", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_poly_reduce_seq
